decode_execute_pipe: RTL and testbench

- Parametrised, pipelined successor to the 4-bit combinational decode-and-execute ALU.
- Accepts one operation per cycle (rs, rt, sel) over a valid/ready handshake.
- Executes it in a two-stage registered pipeline and delivers rd over a valid/ready output handshake with full backpressure.
- Sits between the lab's instruction source (FSM or testbench driver) and the result sink.

---
 rtl/decode_execute_pipe.sv | 155 +++++++++++++++
 tb/tb_decode_execute_pipe.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/decode_execute_pipe.sv
// Two-stage valid/ready decode-and-execute ALU: stage 1 captures the operation, stage 2 holds the result.
// Optional status flags (flag_z/flag_c/flag_v) are enabled by defining DAE_STATUS_FLAGS_EN.
module decode_execute_pipe #(
    parameter int WIDTH   = 8,
    parameter int SHAMT_W = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] rs,
    input  logic [WIDTH-1:0] rt,
    input  logic [2:0]       sel,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] rd,
    output logic             busy
`ifdef DAE_STATUS_FLAGS_EN
    ,
    output logic             flag_z,
    output logic             flag_c,
    output logic             flag_v
`endif
);

    typedef enum logic [2:0] {
        OP_SUB = 3'b000,
        OP_ADD = 3'b001,
        OP_OR  = 3'b010,
        OP_AND = 3'b011,
        OP_SRA = 3'b100,
        OP_ROL = 3'b101,
        OP_SLT = 3'b110,
        OP_SEQ = 3'b111
    } op_t;

    logic             s1_valid_reg;
    logic [WIDTH-1:0] s1_rs_reg;
    logic [WIDTH-1:0] s1_rt_reg;
    logic [2:0]       s1_sel_reg;
    logic             s2_valid_reg;
    logic [WIDTH-1:0] rd_reg;

    logic             s2_load;
    logic             s1_advance;
    logic             in_fire;
    logic [WIDTH-1:0] rd_next;
    logic [WIDTH-1:0] sum_next;
    logic [WIDTH-1:0] diff_next;

    // in_ready depends combinationally on out_ready so a full pipe can still stream at one op per cycle
    assign s2_load    = !s2_valid_reg || out_ready;
    assign s1_advance = s1_valid_reg && s2_load;
    assign in_ready   = !s1_valid_reg || s1_advance;
    assign in_fire    = in_valid && in_ready;

    assign out_valid = s2_valid_reg;
    assign rd        = rd_reg;
    assign busy      = s1_valid_reg || s2_valid_reg;

    assign sum_next  = s1_rs_reg + s1_rt_reg;
    assign diff_next = s1_rs_reg - s1_rt_reg;

    always_comb begin
        rd_next = '0;
        case (op_t'(s1_sel_reg))
            OP_SUB: rd_next = diff_next;
            OP_ADD: rd_next = sum_next;
            OP_OR:  rd_next = s1_rs_reg | s1_rt_reg;
            OP_AND: rd_next = s1_rs_reg & s1_rt_reg;
            OP_SRA: rd_next = $signed(s1_rt_reg) >>> s1_rs_reg[SHAMT_W-1:0];
            // A zero amount shifts the right-hand term by WIDTH, which yields 0 and leaves rs intact
            OP_ROL: rd_next = (s1_rs_reg << s1_rt_reg[SHAMT_W-1:0])
                            | (s1_rs_reg >> (WIDTH - int'(s1_rt_reg[SHAMT_W-1:0])));
            OP_SLT: rd_next = {{(WIDTH-1){1'b0}}, ($signed(s1_rs_reg) < $signed(s1_rt_reg))};
            OP_SEQ: rd_next = {{(WIDTH-1){1'b0}}, (s1_rs_reg == s1_rt_reg)};
            default: rd_next = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_reg <= 1'b0;
            s1_rs_reg    <= '0;
            s1_rt_reg    <= '0;
            s1_sel_reg   <= '0;
        end else if (in_fire) begin
            s1_valid_reg <= 1'b1;
            s1_rs_reg    <= rs;
            s1_rt_reg    <= rt;
            s1_sel_reg   <= sel;
        end else if (s1_advance) begin
            s1_valid_reg <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s2_valid_reg <= 1'b0;
            rd_reg       <= '0;
        end else if (s1_advance) begin
            s2_valid_reg <= 1'b1;
            rd_reg       <= rd_next;
        end else if (out_ready) begin
            s2_valid_reg <= 1'b0;
        end
    end

`ifdef DAE_STATUS_FLAGS_EN
    logic flag_z_reg;
    logic flag_c_reg;
    logic flag_v_reg;
    logic flag_c_next;
    logic flag_v_next;

    // Carry of an unsigned add shows up as a wrapped sum smaller than an operand
    always_comb begin
        flag_c_next = 1'b0;
        flag_v_next = 1'b0;
        case (op_t'(s1_sel_reg))
            OP_ADD: begin
                flag_c_next = (sum_next < s1_rs_reg);
                flag_v_next = (s1_rs_reg[WIDTH-1] == s1_rt_reg[WIDTH-1])
                           && (sum_next[WIDTH-1] != s1_rs_reg[WIDTH-1]);
            end
            OP_SUB: begin
                flag_c_next = (s1_rs_reg < s1_rt_reg);
                flag_v_next = (s1_rs_reg[WIDTH-1] != s1_rt_reg[WIDTH-1])
                           && (diff_next[WIDTH-1] != s1_rs_reg[WIDTH-1]);
            end
            default: begin
                flag_c_next = 1'b0;
                flag_v_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            flag_z_reg <= 1'b0;
            flag_c_reg <= 1'b0;
            flag_v_reg <= 1'b0;
        end else if (s1_advance) begin
            flag_z_reg <= (rd_next == '0);
            flag_c_reg <= flag_c_next;
            flag_v_reg <= flag_v_next;
        end
    end

    assign flag_z = flag_z_reg;
    assign flag_c = flag_c_reg;
    assign flag_v = flag_v_reg;
`endif

endmodule

// File: tb/tb_decode_execute_pipe.sv
// Directed and scoreboard bench for decode_execute_pipe at WIDTH=8; flag checks when DAE_STATUS_FLAGS_EN is defined.
`timescale 1ns/1ps
module tb_decode_execute_pipe;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] rs;
    logic [7:0] rt;
    logic [2:0] sel;
    logic       out_valid;
    logic       out_ready;
    logic [7:0] rd;
    logic       busy;
`ifdef DAE_STATUS_FLAGS_EN
    logic       flag_z;
    logic       flag_c;
    logic       flag_v;
`endif

    int n_checks = 0;
    int n_errors = 0;

    always #5 clk = ~clk;

    decode_execute_pipe #(.WIDTH(8), .SHAMT_W(3)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .rs        (rs),
        .rt        (rt),
        .sel       (sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .rd        (rd),
        .busy      (busy)
`ifdef DAE_STATUS_FLAGS_EN
        ,
        .flag_z    (flag_z),
        .flag_c    (flag_c),
        .flag_v    (flag_v)
`endif
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        in_valid = v;
        sel      = s;
        rs       = a;
        rt       = b;
    endtask

    // Reference ALU written bit-by-bit, independent of the RTL formulation
    function automatic logic [7:0] model(input logic [2:0] s, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] r;
        r = 8'h00;
        case (s)
            3'd0: r = a - b;
            3'd1: r = a + b;
            3'd2: r = a | b;
            3'd3: r = a & b;
            3'd4: begin
                r = b;
                for (int k = 0; k < int'(a[2:0]); k++) r = {r[7], r[7:1]};
            end
            3'd5: begin
                r = a;
                for (int k = 0; k < int'(b[2:0]); k++) r = {r[6:0], r[7]};
            end
            3'd6: begin
                if (a[7] != b[7]) r = a[7] ? 8'h01 : 8'h00;
                else              r = (a < b) ? 8'h01 : 8'h00;
            end
            default: r = (a == b) ? 8'h01 : 8'h00;
        endcase
        return r;
    endfunction

    // Directed vectors: eight opcodes, then boundary cases, then ROL by zero
    localparam int NV = 14;
    logic [2:0] v_sel [NV] = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7,
                               3'd0, 3'd4, 3'd5, 3'd6, 3'd7, 3'd5};
    logic [7:0] v_rs  [NV] = '{8'h30, 8'hF0, 8'h0F, 8'h3C, 8'h02, 8'h96, 8'h05, 8'h12,
                               8'h00, 8'h07, 8'h81, 8'h80, 8'h5A, 8'hC3};
    logic [7:0] v_rt  [NV] = '{8'h10, 8'h20, 8'hA0, 8'h0F, 8'h90, 8'h03, 8'hFE, 8'h13,
                               8'h01, 8'h80, 8'h01, 8'h01, 8'h5A, 8'h08};
    logic [7:0] v_exp [NV] = '{8'h20, 8'h10, 8'hAF, 8'h0C, 8'hE4, 8'hB4, 8'h00, 8'h00,
                               8'hFF, 8'hFF, 8'h03, 8'h01, 8'h01, 8'hC3};

    logic [2:0] b_sel [4] = '{3'd1, 3'd0, 3'd2, 3'd3};
    logic [7:0] b_rs  [4] = '{8'h01, 8'h10, 8'hF0, 8'hFF};
    logic [7:0] b_rt  [4] = '{8'h02, 8'h01, 8'h0F, 8'h5A};
    logic [7:0] b_exp [4] = '{8'h03, 8'h0F, 8'hFF, 8'h5A};

    logic [7:0] sb_q[$];

    initial begin
        int issued;
        int got;
        int cyc;
        logic fire_in;

        rst = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        tick();
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd", {24'd0, rd}, 32'd0);
        rst = 1'b0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);

        // Streaming at full rate: each result shows one edge after capture
        for (int i = 0; i <= NV; i++) begin
            if (i < NV) drive(1'b1, v_sel[i], v_rs[i], v_rt[i]);
            else        drive(1'b0, 3'd0, 8'h00, 8'h00);
            #1;
            check($sformatf("stream_in_ready[%0d]", i), {31'd0, in_ready}, 32'd1);
            tick();
            if (i == 0) begin
                check("stream_first_latency", {31'd0, out_valid}, 32'd0);
            end else begin
                check($sformatf("stream_valid[%0d]", i - 1), {31'd0, out_valid}, 32'd1);
                check($sformatf("stream_rd[%0d]", i - 1), {24'd0, rd}, {24'd0, v_exp[i - 1]});
            end
        end
        tick();
        check("stream_drained", {31'd0, out_valid}, 32'd0);

        // Backpressure: two ops fill the pipe, the third must stall
        out_ready = 1'b0;
        drive(1'b1, b_sel[0], b_rs[0], b_rt[0]);
        tick();
        drive(1'b1, b_sel[1], b_rs[1], b_rt[1]);
        tick();
        drive(1'b1, b_sel[2], b_rs[2], b_rt[2]);
        #1;
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        check("bp_out_valid", {31'd0, out_valid}, 32'd1);
        check("bp_busy", {31'd0, busy}, 32'd1);
        check("bp_rd_first", {24'd0, rd}, {24'd0, b_exp[0]});
        tick();
        check("bp_rd_held", {24'd0, rd}, {24'd0, b_exp[0]});
        check("bp_in_ready_held", {31'd0, in_ready}, 32'd0);
        issued = 2;
        got = 0;
        out_ready = 1'b1;
        for (cyc = 0; cyc < 20 && got < 4; cyc++) begin
            if (issued < 4) drive(1'b1, b_sel[issued], b_rs[issued], b_rt[issued]);
            else            drive(1'b0, 3'd0, 8'h00, 8'h00);
            #1;
            fire_in = in_valid && in_ready;
            if (out_valid) begin
                check($sformatf("bp_drain_rd[%0d]", got), {24'd0, rd}, {24'd0, b_exp[got]});
                got++;
            end
            tick();
            if (fire_in) issued++;
        end
        check("bp_result_count", got, 32'd4);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        #1;
        check("bp_no_duplicate", {31'd0, out_valid}, 32'd0);

        // Reset with both stages full drops everything in flight
        out_ready = 1'b0;
        drive(1'b1, 3'd1, 8'h11, 8'h22);
        tick();
        drive(1'b1, 3'd2, 8'h40, 8'h04);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        check("mid_rst_rd", {24'd0, rd}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        out_ready = 1'b1;
        drive(1'b1, 3'd7, 8'h5A, 8'h5A);
        tick();
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        check("post_rst_valid", {31'd0, out_valid}, 32'd1);
        check("post_rst_rd", {24'd0, rd}, 32'd1);
        tick();

        // Random traffic with a scoreboard against the reference model
        issued = 0;
        got = 0;
        for (cyc = 0; cyc < 4000 && got < 300; cyc++) begin
            drive((issued < 300) && ($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)),
                  8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)));
            out_ready = ($urandom_range(0, 2) != 0);
            #1;
            if (out_valid && out_ready) begin
                if (sb_q.size() == 0) begin
                    check("rand_unexpected_output", 32'd1, 32'd0);
                end else begin
                    check($sformatf("rand_rd[%0d]", got), {24'd0, rd}, {24'd0, sb_q.pop_front()});
                end
                got++;
            end
            if (in_valid && in_ready) begin
                sb_q.push_back(model(sel, rs, rt));
                issued++;
            end
            tick();
        end
        check("rand_result_count", got, 32'd300);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        out_ready = 1'b1;
        tick();
        tick();

`ifdef DAE_STATUS_FLAGS_EN
        drive(1'b1, 3'd1, 8'h7F, 8'h01);
        tick();
        drive(1'b1, 3'd1, 8'hFF, 8'h01);
        tick();
        check("flags_ovf_rd", {24'd0, rd}, 32'h80);
        check("flags_ovf_v", {31'd0, flag_v}, 32'd1);
        check("flags_ovf_c", {31'd0, flag_c}, 32'd0);
        check("flags_ovf_z", {31'd0, flag_z}, 32'd0);
        drive(1'b0, 3'd0, 8'h00, 8'h00);
        tick();
        check("flags_carry_rd", {24'd0, rd}, 32'h00);
        check("flags_carry_c", {31'd0, flag_c}, 32'd1);
        check("flags_carry_z", {31'd0, flag_z}, 32'd1);
        check("flags_carry_v", {31'd0, flag_v}, 32'd0);
`endif

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
